nios2_oci_dct_capture: RTL and testbench

NIOS2_OCI_DCT_CAPTURE -- requirements
Module: nios2_oci_dct_capture

---
 rtl/nios2_oci_dct_capture.sv | 107 ++++++++++
 tb/tb_nios2_oci_dct_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_oci_dct_capture.sv
// Debug-trace capture: detects dct_count frame changes and queues {count, data[, timestamp]} in a FWFT FIFO.
// Optional feature macro: NIOS2_OCI_DCT_CAPTURE_TIMESTAMP_EN appends a 16-bit free-running timestamp.
module nios2_oci_dct_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 8,
`ifdef NIOS2_OCI_DCT_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W = CNT_W + DATA_W + 16,
`else
  localparam int ENTRY_W = CNT_W + DATA_W,
`endif
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]   dct_count,
  input  logic               test_ending,
  input  logic               test_has_ended,
  output logic [ENTRY_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic [15:0]        frames,
  output logic               done
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   prev_count;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               empty, full, frame_det, push, pop;
  logic [ENTRY_W-1:0] entry;

`ifdef NIOS2_OCI_DCT_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 16'd1;
  end

  assign entry = {dct_count, dct_buffer, ts};
`else
  assign entry = {dct_count, dct_buffer};
`endif

  always_comb begin
    empty     = (level == '0);
    full      = (level == LVL_W'(DEPTH));
    out_valid = !empty && (state != DONE);
    done      = (state == DONE);
    pop       = out_valid && out_ready;
    frame_det = (state == RUN) && (dct_count != prev_count);
    // A frame coinciding with test_has_ended would be discarded by the flush anyway.
    push      = frame_det && !test_has_ended && (!full || pop);
    out_data  = mem[rd_ptr];

    state_nxt = state;
    case (state)
      RUN:     if (test_ending) state_nxt = FLUSH;
      FLUSH:   if (empty)       state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
    if (test_has_ended) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      prev_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      frames     <= '0;
    end else begin
      state      <= state_nxt;
      prev_count <= dct_count;
      if (test_has_ended) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
        if (frame_det && !push) overflow <= 1'b1;
      end
      if (push && frames != 16'hFFFF) frames <= frames + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Scoreboard bench for nios2_oci_dct_capture: queue-based reference model, randomized and directed frames.
module tb_nios2_oci_dct_capture;
  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 8;
`ifdef NIOS2_OCI_DCT_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W = CNT_W + DATA_W + 16;
`else
  localparam int ENTRY_W = CNT_W + DATA_W;
`endif
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [DATA_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               test_ending, test_has_ended;
  logic [ENTRY_W-1:0] out_data;
  logic               out_valid, out_ready;
  logic [LVL_W-1:0]   level;
  logic               overflow;
  logic [15:0]        frames;
  logic               done;

  nios2_oci_dct_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .frames(frames), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef logic [ENTRY_W-1:0] entry_t;
  entry_t sbq[$];

  // Reference model: phase 0=capturing, 1=draining, 2=finished.
  int               m_phase, m_level, m_frames;
  bit               m_ovf;
  bit               started = 1'b0;
  logic [CNT_W-1:0] m_prev;
  logic [15:0]      m_ts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluated 1 time unit before each rising edge, with inputs stable.
  task automatic model_step();
    bit m_valid, m_pop, frame, acc;
    int old_level;
    entry_t e;
    if (reset) begin
      m_phase = 0; m_level = 0; m_frames = 0; m_ovf = 1'b0;
      m_prev = '0; m_ts = '0; sbq.delete(); started = 1'b1;
      return;
    end
    old_level = m_level;
    m_valid   = (m_phase != 2) && (m_level > 0);
    m_pop     = m_valid && out_ready;
    frame     = (m_phase == 0) && (dct_count != m_prev);
    if (test_has_ended) begin
      m_phase = 2; m_level = 0; sbq.delete();
    end else begin
      acc = frame && ((m_level < DEPTH) || m_pop);
      if (acc) begin
`ifdef NIOS2_OCI_DCT_CAPTURE_TIMESTAMP_EN
        e = {dct_count, dct_buffer, m_ts};
`else
        e = {dct_count, dct_buffer};
`endif
        sbq.push_back(e);
        if (m_frames < 65535) m_frames++;
        m_level++;
      end else if (frame) m_ovf = 1'b1;
      if (m_pop) m_level--;
      if (m_phase == 0 && test_ending) m_phase = 1;
      else if (m_phase == 1 && old_level == 0) m_phase = 2;
    end
    m_prev = dct_count;
    m_ts   = m_ts + 16'd1;
  endtask

  // Monitor: compares registered DUT outputs against the model and drains the scoreboard.
  always @(negedge clk) begin
    #3;
    if (started && !reset) begin
      chk("level", level, m_level);
      chk("out_valid", out_valid, (m_phase != 2) && (m_level > 0));
      chk("overflow", overflow, m_ovf);
      chk("frames", frames, m_frames);
      chk("done", done, m_phase == 2);
      if (out_valid) begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          chk("head_data", out_data, sbq[0]);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    #4;
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0;
    out_ready = 1'b0; dct_count = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic frame(input logic [CNT_W-1:0] c);
    dct_count  = c;
    dct_buffer = DATA_W'($urandom);
    tick();
  endtask

  initial begin
    reset = 1'b1; dct_count = '0; dct_buffer = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_frames", frames, 0);
    chk("rst_done", done, 0);

    // Two frames with a ready consumer.
    out_ready = 1'b1;
    dct_count = 4'd1; dct_buffer = 30'h1; tick();
    dct_count = 4'd2; dct_buffer = 30'h2; tick();
    repeat (4) tick();
    chk("two_frames", frames, 2);
    chk("two_ovf", overflow, 0);

    // Nine frames into a stalled FIFO, then drain.
    do_reset();
    for (int i = 1; i <= 9; i++) frame(CNT_W'(i));
    chk("full_level", level, 8);
    chk("full_ovf", overflow, 1);
    chk("full_frames", frames, 8);
    out_ready = 1'b1;
    repeat (10) tick();
    chk("drained", level, 0);

    // Full FIFO: push and pop in the same cycle.
    do_reset();
    for (int i = 1; i <= 8; i++) frame(CNT_W'(i));
    chk("pre_level", level, 8);
    out_ready = 1'b1; frame(4'd9);
    out_ready = 1'b0; tick();
    chk("sim_level", level, 8);
    chk("sim_ovf", overflow, 0);
    chk("sim_frames", frames, 9);

    // Orderly stop with 3 queued; later count changes ignored.
    do_reset();
    for (int i = 1; i <= 3; i++) frame(CNT_W'(i));
    test_ending = 1'b1; out_ready = 1'b1; tick();
    for (int i = 4; i <= 9; i++) frame(CNT_W'(i));
    chk("flush_done", done, 1);
    chk("flush_frames", frames, 3);

    // Forced stop with 4 queued.
    do_reset();
    for (int i = 1; i <= 4; i++) frame(CNT_W'(i));
    test_has_ended = 1'b1; test_ending = 1'b1; tick();
    chk("abort_done", done, 1);
    chk("abort_level", level, 0);
    chk("abort_valid", out_valid, 0);
    test_has_ended = 1'b0; test_ending = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 1; i <= 3; i++) frame(CNT_W'(i));
    test_ending = 1'b1; tick(); tick();
    do_reset();
    chk("midrst_done", done, 0);
    chk("midrst_level", level, 0);

    // Randomized sessions.
    for (int r = 0; r < 16; r++) begin
      int len, te_at, th_at;
      do_reset();
      len   = $urandom_range(40, 250);
      te_at = $urandom_range(10, len + 20);
      th_at = ((r % 4) == 3) ? $urandom_range(5, len) : len + 100;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < 55) dct_count = CNT_W'($urandom);
        dct_buffer     = DATA_W'($urandom);
        out_ready      = ($urandom_range(0, 99) < ((r % 2) ? 30 : 70));
        test_ending    = (c >= te_at);
        test_has_ended = (c >= th_at);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
